trivium_stream_decrypt: RTL and testbench
=========================================

// Module: trivium_stream_decrypt
// PURPOSE
//  Receive-side Trivium decipher: rekeyed by a start pulse, warms up internally, then XORs a
//  valid/ready ciphertext stream with DATA_W keystream bits per beat to emit plaintext.
//  Counterpart of the transmit-side keystream/encrypt path; both ends must load the same KEY/IV.
//  Warm-up is a counted FSM, never a combinational loop.
// PARAMETERS
//  DATA_W       8     bits per stream beat = keystream bits produced per cipher advance
//  INIT_ROUNDS  1152  warm-up single-bit rounds; INIT_ROUNDS % DATA_W == 0 (elaboration error otherwise)
// PORTS
//  clk        in   1       rising-edge clock, sole clock domain
//  rst        in   1       synchronous reset, active high
//  start      in   1       rekey pulse; samples key/iv on the same edge
//  key        in   80      [80:1] cipher key
//  iv         in   80      [80:1] initialisation vector
//  busy       out  1       high during warm-up (INIT)
//  in_valid   in   1       ciphertext beat valid
//  in_ready   out  1       block accepts a beat
//  in_data    in   DATA_W  ciphertext; bit 0 uses the earliest keystream bit
//  out_valid  out  1       plaintext beat valid
//  out_ready  in   1       downstream accepts
//  out_data   out  DATA_W  plaintext
// BEHAVIOUR
//  State s93[93:1], s84[84:1], s111[111:1].
//  Load: s93={13'b0,key}; s84={4'b0,iv}; s111={3'b111,108'b0}.
//  One bit-round:
//   t1=s93[66]^s93[93]; t2=s84[69]^s84[84]; t3=s111[66]^s111[111]; z=t1^t2^t3
//   a1=t1^(s93[91]&s93[92])^s84[78]; a2=t2^(s84[82]&s84[83])^s111[87]
//   a3=t3^(s111[109]&s111[110])^s93[69]
//   shift in: s93<=a3, s84<=a1, s111<=a2, each at bit 1
//  Step = DATA_W chained bit-rounds in one cycle; z of round k -> ks[k].
//  FSM IDLE -> INIT -> RUN.
//   IDLE: in_ready=0.
//   start (any state, including INIT/RUN): load state, cnt=INIT_ROUNDS/DATA_W-1,
//    clear out_valid, go INIT. busy=1 from the next cycle.
//   INIT: one step per cycle, discarding ks; at cnt==0 go RUN, so busy is high exactly
//    INIT_ROUNDS/DATA_W cycles.
//   RUN: in_ready = !out_valid || out_ready (1-deep output register, no combinational
//    valid->ready path).
//  Accept (in_valid&&in_ready): out_data<=in_data^ks, out_valid<=1, cipher steps once.
//   The cipher advances only on accept; stalls keep the state frozen.
//  out_valid clears on out_ready when no new accept occurs; simultaneous drain and accept
//   keeps out_valid=1 with the new data.
//  out_data/out_valid hold while out_valid && !out_ready.
//  start and in_valid on the same edge: start wins, the beat is not accepted (in_ready
//   forced 0 that cycle).
//  rst (any state, mid-stream): state IDLE, busy=0, in_ready=0, out_valid=0, out_data=0,
//   cipher regs=0, cnt=0; rst overrides start.
// CONFIGURATION
//  TRIVIUM_DEC_LAST_EN defined: adds ports in_last (in, 1) and out_last (out, 1, reset 0).
//   out_last is registered alongside out_data.
//   When a beat with in_last=1 is accepted, the FSM goes to IDLE and needs a new start;
//   out_valid still drains normally.
//  TRIVIUM_DEC_LAST_EN undefined: no last ports; RUN persists until start or rst.
// STRUCTURE
//  Package trivium_pkg: register lengths (93/84/111), tap constants, state enum {IDLE,INIT,RUN},
//   load function for the key/iv layout.
//  Sub-module trivium_step_unroll (DATA_W param): combinational state_in -> state_out + ks[DATA_W-1:0].
//   The top level holds the registers, FSM, counter and handshake.
// TESTING
//  1 Warm-up timing: rst 2 cycles; start with key=0, iv=0 at cycle 0 -> busy high for
//    cycles 1..144; in_ready=1 at cycle 145.
//  2 Known stream: key=80'h0, iv=80'h0, 16 beats in_data=8'h00, out_ready=1 -> out_data equals
//    keystream bytes from a bit-serial golden model (bit 0 first).
//  3 Round trip: key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA98765432100000, encrypt
//    8'h00..8'h3F with the golden model -> out_data sequence equals 8'h00..8'h3F.
//  4 Backpressure: out_ready low for 5 cycles mid-stream -> in_ready=0 after one beat;
//    out_data held; no keystream skipped after release (matches case 2 bytes).
//  5 Rekey mid-RUN: start with new key after beat 3 -> out_valid drops next cycle;
//    busy 144 cycles; first output uses the fresh keystream.
//  6 rst during INIT at cycle 50 -> busy=0, in_ready=0, out_valid=0 next cycle; stays IDLE
//    without start. With TRIVIUM_DEC_LAST_EN: in_last on beat 4 -> out_last on beat 4;
//    in_ready=0 afterwards.

Source files
------------

// File: rtl/trivium_pkg.sv
// trivium_pkg: Trivium register geometry, tap positions, FSM states and key/iv load layout.
package trivium_pkg;
  localparam int A_LEN = 93;
  localparam int B_LEN = 84;
  localparam int C_LEN = 111;
  localparam int A_T = 66, A_AND = 91, A_X = 69;
  localparam int B_T = 69, B_AND = 82, B_X = 78;
  localparam int C_T = 66, C_AND = 109, C_X = 87;
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_e;
  typedef struct packed {
    logic [A_LEN:1] a;
    logic [B_LEN:1] b;
    logic [C_LEN:1] c;
  } trivium_state_t;
  function automatic trivium_state_t trivium_load(input logic [80:1] key, input logic [80:1] iv);
    trivium_state_t s;
    s.a = {13'b0, key};
    s.b = {4'b0, iv};
    s.c = {3'b111, 108'b0};
    return s;
  endfunction
endpackage

// File: rtl/trivium_stream_decrypt_step.sv
// trivium_step_unroll: DATA_W chained Trivium bit-rounds in one combinational step.
module trivium_step_unroll
  import trivium_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  trivium_state_t    state_in,
  output trivium_state_t    state_out,
  output logic [DATA_W-1:0] ks
);
  always_comb begin
    trivium_state_t s;
    logic t1, t2, t3, a1, a2, a3;
    s = state_in;
    ks = '0;
    for (int k = 0; k < DATA_W; k++) begin
      t1 = s.a[A_T] ^ s.a[A_LEN];
      t2 = s.b[B_T] ^ s.b[B_LEN];
      t3 = s.c[C_T] ^ s.c[C_LEN];
      ks[k] = t1 ^ t2 ^ t3;
      a1 = t1 ^ (s.a[A_AND] & s.a[A_AND+1]) ^ s.b[B_X];
      a2 = t2 ^ (s.b[B_AND] & s.b[B_AND+1]) ^ s.c[C_X];
      a3 = t3 ^ (s.c[C_AND] & s.c[C_AND+1]) ^ s.a[A_X];
      s.a = {s.a[A_LEN-1:1], a3};
      s.b = {s.b[B_LEN-1:1], a1};
      s.c = {s.c[C_LEN-1:1], a2};
    end
    state_out = s;
  end
endmodule

// File: rtl/trivium_stream_decrypt.sv
// trivium_stream_decrypt: Trivium receive decipher with counted warm-up and 1-deep output register.
// Define TRIVIUM_DEC_LAST_EN to add in_last/out_last framing that returns to IDLE after the last beat.
module trivium_stream_decrypt
  import trivium_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [80:1]       key,
  input  logic [80:1]       iv,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef TRIVIUM_DEC_LAST_EN
  input  logic              in_last,
  output logic              out_last,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  localparam int STEPS = INIT_ROUNDS / DATA_W;
  localparam int CW = $clog2(STEPS + 1);
  if (INIT_ROUNDS % DATA_W != 0) begin : g_bad_rounds
    $error("INIT_ROUNDS must be a multiple of DATA_W");
  end
  state_e st, st_n;
  trivium_state_t s, s_step;
  logic [DATA_W-1:0] ks;
  logic [CW-1:0] cnt;
  logic accept;
  trivium_step_unroll #(.DATA_W(DATA_W)) u_step (
    .state_in (s),
    .state_out(s_step),
    .ks       (ks)
  );
  assign busy = st == INIT;
  // start blocks acceptance so a rekey never consumes a beat with stale keystream
  assign in_ready = st == RUN && !start && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  always_comb begin
    st_n = st;
    if (start) st_n = INIT;
    else if (busy && cnt == '0) st_n = RUN;
`ifdef TRIVIUM_DEC_LAST_EN
    else if (accept && in_last) st_n = IDLE;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      s <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
`ifdef TRIVIUM_DEC_LAST_EN
      out_last <= 1'b0;
`endif
    end else begin
      st <= st_n;
      if (start) begin
        s <= trivium_load(key, iv);
        cnt <= CW'(STEPS - 1);
        out_valid <= 1'b0;
      end else if (busy) begin
        s <= s_step;
        cnt <= (cnt == '0) ? '0 : cnt - CW'(1);
      end else if (accept) begin
        s <= s_step;
        out_data <= in_data ^ ks;
        out_valid <= 1'b1;
`ifdef TRIVIUM_DEC_LAST_EN
        out_last <= in_last;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_trivium_stream_decrypt.sv
// tb_trivium_stream_decrypt: directed checks of trivium_stream_decrypt against a bit-serial Trivium model.
module tb_trivium_stream_decrypt;
  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready, busy, in_ready, out_valid;
  logic [79:0] key, iv;
  logic [7:0] in_data, out_data;
`ifdef TRIVIUM_DEC_LAST_EN
  logic in_last, out_last;
`endif
  int checks = 0;
  int failures = 0;
  logic [288:1] gs;
  logic [7:0] ks2 [16];
  logic [7:0] ks3 [64];
  localparam logic [79:0] K1 = 80'h0123456789ABCDEF0123;
  localparam logic [79:0] V1 = 80'hFEDCBA98765432100000;

  always #5 clk = ~clk;

  trivium_stream_decrypt #(.DATA_W(8), .INIT_ROUNDS(1152)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .iv       (iv),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef TRIVIUM_DEC_LAST_EN
    .in_last  (in_last),
    .out_last (out_last),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 400) begin
      n++;
      tick();
    end
  endtask

  // Standard 288-bit Trivium numbering s1..s288
  task automatic ground(output logic z);
    logic t1, t2, t3;
    t1 = gs[66] ^ gs[93];
    t2 = gs[162] ^ gs[177];
    t3 = gs[243] ^ gs[288];
    z = t1 ^ t2 ^ t3;
    t1 = t1 ^ (gs[91] & gs[92]) ^ gs[171];
    t2 = t2 ^ (gs[175] & gs[176]) ^ gs[264];
    t3 = t3 ^ (gs[286] & gs[287]) ^ gs[69];
    gs[93:1] = {gs[92:1], t3};
    gs[177:94] = {gs[176:94], t1};
    gs[288:178] = {gs[287:178], t2};
  endtask

  task automatic gbyte(output logic [7:0] b);
    for (int k = 0; k < 8; k++) ground(b[k]);
  endtask

  task automatic gload(input logic [79:0] k, input logic [79:0] v);
    logic z;
    gs = '0;
    gs[80:1] = k;
    gs[173:94] = v;
    gs[288:286] = 3'b111;
    repeat (1152) ground(z);
  endtask

  initial begin
    int n;
    gload(80'h0, 80'h0);
    for (int i = 0; i < 16; i++) gbyte(ks2[i]);
    gload(K1, V1);
    for (int i = 0; i < 64; i++) gbyte(ks3[i]);
    rst = 1'b1; start = 1'b0; key = '0; iv = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef TRIVIUM_DEC_LAST_EN
    in_last = 1'b0;
`endif
    @(negedge clk);
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    // warm-up timing
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_busy(n);
    check("warm_cycles", n, 144);
    check("warm_ready", in_ready, 1);
    // known keystream, then backpressure mid-stream
    in_valid = 1'b1; in_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("ks_beat%0d", i), out_data, ks2[i]);
      check("ks_valid", out_valid, 1);
    end
    out_ready = 1'b0;
    #1 check("bp_ready_low", in_ready, 0);
    repeat (5) begin
      tick();
      check("bp_data_hold", out_data, ks2[7]);
      check("bp_valid_hold", out_valid, 1);
      check("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int i = 8; i < 16; i++) begin
      tick();
      check($sformatf("ks_beat%0d", i), out_data, ks2[i]);
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", out_valid, 0);
    // round trip with a non-trivial key/iv
    key = K1; iv = V1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_busy(n);
    check("rt_warm", n, 144);
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_data = 8'(i) ^ ks3[i];
      tick();
      check($sformatf("rt_beat%0d", i), out_data, 32'(i));
    end
    in_valid = 1'b0;
    tick();
    // rekey mid-RUN, start coincident with a valid beat
    key = '0; iv = '0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_busy(n);
    in_valid = 1'b1; in_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rk_pre%0d", i), out_data, ks2[i]);
    end
    key = K1; iv = V1; start = 1'b1;
    #1 check("rk_start_blocks", in_ready, 0);
    tick();
    start = 1'b0;
    check("rk_valid_drop", out_valid, 0);
    check("rk_busy", busy, 1);
    wait_busy(n);
    check("rk_warm", n, 144);
    tick();
    check("rk_first", out_data, ks3[0]);
    check("rk_first_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    // reset during warm-up
    key = '0; iv = '0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    check("mid_init_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_init_busy", busy, 0);
    check("rst_init_ready", in_ready, 0);
    check("rst_init_valid", out_valid, 0);
    check("rst_init_data", out_data, 0);
    in_valid = 1'b1;
    repeat (10) tick();
    check("idle_busy", busy, 0);
    check("idle_ready", in_ready, 0);
    check("idle_valid", out_valid, 0);
    in_valid = 1'b0;
`ifdef TRIVIUM_DEC_LAST_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_busy(n);
    in_valid = 1'b1; in_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 3);
      tick();
      check($sformatf("last_data%0d", i), out_data, ks2[i]);
      check($sformatf("last_flag%0d", i), out_last, 32'(i == 3));
    end
    in_last = 1'b0;
    check("last_ready", in_ready, 0);
    tick();
    check("last_drain", out_valid, 0);
    check("last_idle_ready", in_ready, 0);
    in_valid = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
